// File: rtl/uart_tx_param_if.sv
// Handshake and line-status bundle between a word producer and uart_tx_param.
// master drives words and the transmit permit; slave is the transmitter.
interface uart_tx_param_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_BITS-1:0]           in_data;
    logic                           in_valid;
    logic                           in_ready;
    logic                           tx_en;
    logic                           serial_out;
    logic                           tx_busy;
    logic                           tx_done;
    logic [$clog2(FIFO_DEPTH):0]    fifo_count;

    modport master (
        output in_data, in_valid, tx_en,
        input  in_ready, serial_out, tx_busy, tx_done, fifo_count
    );

    modport slave (
        input  in_data, in_valid, tx_en,
        output in_ready, serial_out, tx_busy, tx_done, fifo_count
    );
endinterface

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: FIFO feeds a start/data/parity/stop serializer.
// First start bit one cycle after the write; in_ready drops only when the FIFO is full.

module uart_tx_param_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_vld,
    output logic                      wr_rdy,
    input  logic [WIDTH-1:0]          wr_dat,
    input  logic                      rd_rdy,
    output logic                      rd_vld,
    output logic [WIDTH-1:0]          rd_dat,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_fire;
    logic             rd_fire;

    // Full refuses a write even when a pop frees a slot in the same cycle.
    assign wr_rdy  = count < (AW+1)'(DEPTH);
    assign rd_vld  = count != '0;
    assign wr_fire = wr_vld && wr_rdy;
    assign rd_fire = rd_rdy && rd_vld;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_fire && !rd_fire) begin
                count <= count + 1'b1;
            end else if (rd_fire && !wr_fire) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_param_if.slave  bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             ODD_PAR   = (PARITY_MODE == 2);
    localparam logic             HAS_PAR   = (PARITY_MODE != 0);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]                  state;
    logic [CNT_W-1:0]            baud_cnt;
    logic [BIT_W-1:0]            bit_cnt;
    logic [DATA_BITS-1:0]        shreg;
    logic                        parity_bit;
    logic                        serial_q;

    logic                        fifo_rdy;
    logic                        fifo_vld;
    logic [DATA_BITS-1:0]        fifo_dat;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

    logic                        bit_end;
    logic                        frame_end;
    logic                        pop;

    uart_tx_param_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (bus.in_valid),
        .wr_rdy (fifo_rdy),
        .wr_dat (bus.in_data),
        .rd_rdy (pop),
        .rd_vld (fifo_vld),
        .rd_dat (fifo_dat),
        .count  (fifo_cnt)
    );

    assign bit_end   = (baud_cnt == '0);
    assign frame_end = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
    // A new frame may start from IDLE or straight out of the last stop bit.
    assign pop       = fifo_vld && bus.tx_en && ((state == IDLE) || frame_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            serial_q   <= 1'b1;
        end else if (pop) begin
            state      <= START;
            baud_cnt   <= BAUD_LAST;
            bit_cnt    <= '0;
            shreg      <= fifo_dat;
            parity_bit <= (^fifo_dat) ^ ODD_PAR;
            serial_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    serial_q <= 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        baud_cnt <= BAUD_LAST;
                        bit_cnt  <= '0;
                        serial_q <= shreg[0];
                        shreg    <= shreg >> 1;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= BAUD_LAST;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (HAS_PAR) begin
                                state    <= PARITY;
                                serial_q <= parity_bit;
                            end else begin
                                state    <= STOP;
                                serial_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            serial_q <= shreg[0];
                            shreg    <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        baud_cnt <= BAUD_LAST;
                        bit_cnt  <= '0;
                        serial_q <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= BAUD_LAST;
                        if (bit_cnt == STOP_LAST) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                    serial_q <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    serial_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.serial_out = serial_q;
    assign bus.tx_busy    = (state != IDLE);
    assign bus.tx_done    = frame_end;
    assign bus.in_ready   = fifo_rdy;
    assign bus.fifo_count = fifo_cnt;
endmodule
